// File: rtl/alpha_buf_pkg.sv
// Shared types for the alpha window buffer: metric vector, bank lifecycle states, bank count.
package alpha_buf_pkg;

  localparam int unsigned ALPHA_M   = 6;
  localparam int unsigned NUM_BANKS = 2;

  typedef logic signed [7:1][ALPHA_M-1:0] alpha_vec_t;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL,
    DRAINING
  } bank_state_e;

endpackage

// File: rtl/alpha_buf_bank.sv
// One window bank: W-entry store with a synchronous write port, a registered read port,
// and the length / frame flag latched when the window closes.
module alpha_buf_bank
  import alpha_buf_pkg::*;
#(
  parameter  int unsigned DW = 42,
  parameter  int unsigned W  = 32,
  localparam int unsigned AW = $clog2(W)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_close,
  input  logic [AW:0]   i_len,
  input  logic          i_frame,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data,
  output logic [AW:0]   o_len,
  output logic          o_frame
);

  logic [DW-1:0] r_mem [W];
  logic [DW-1:0] r_rd_data;
  logic [AW:0]   r_len;
  logic          r_frame;

  // Storage carries no reset: contents are meaningless until rewritten.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_data <= '0;
      r_len     <= '0;
      r_frame   <= 1'b0;
    end else begin
      if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
      if (i_close) begin
        r_len   <= i_len;
        r_frame <= i_frame;
      end
    end
  end

  assign o_rd_data = r_rd_data;
  assign o_len     = r_len;
  assign o_frame   = r_frame;

endmodule

// File: rtl/alpha_window_buffer.sv
// Ping-pong alpha window store: one bank fills while the other drains in reverse step order.
// Optional ALPHA_WINDOW_BUFFER_PARITY_EN adds per-entry even parity and a sticky o_parity_err.
module alpha_window_buffer
  import alpha_buf_pkg::*;
#(
  parameter  int unsigned M  = ALPHA_M,
  parameter  int unsigned W  = 32,
  localparam int unsigned AW = $clog2(W)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic signed [7:1][M-1:0] i_alpha_in,
  input  logic                    i_in_frame_last,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic signed [7:1][M-1:0] o_alpha_out,
  output logic                    o_out_win_last,
  output logic                    o_out_frame_last,
  output logic [AW:0]             o_win_len
`ifdef ALPHA_WINDOW_BUFFER_PARITY_EN
  ,
  output logic                    o_parity_err
`endif
);

  localparam int unsigned AB = 7 * M;
`ifdef ALPHA_WINDOW_BUFFER_PARITY_EN
  localparam int unsigned DW = AB + 1;
`else
  localparam int unsigned DW = AB;
`endif

  bank_state_e   r_state     [NUM_BANKS];
  bank_state_e   w_state_nxt [NUM_BANKS];
  logic          r_wr_bank, r_rd_bank, r_out_sel;
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic          r_in_ready, r_out_valid, r_win_last, r_frame_last;
  logic [AW:0]   r_win_len;

  logic          w_wr, w_close, w_pop, w_final_pop, w_issue, w_start, w_start_bank;
  logic          w_wr_bank_nxt, w_rd_bank_nxt, w_in_ready_nxt;
  logic [AW:0]   w_close_len;
  logic [DW-1:0] w_wr_data;
  logic [DW-1:0] w_rd_data [NUM_BANKS];
  logic [AW:0]   w_len     [NUM_BANKS];
  logic          w_frame   [NUM_BANKS];

  assign w_wr          = i_in_valid & r_in_ready;
  assign w_close       = w_wr & ((r_wr_ptr == AW'(W - 1)) | i_in_frame_last);
  assign w_close_len   = {1'b0, r_wr_ptr} + (AW+1)'(1);
  assign w_pop         = r_out_valid & i_out_ready;
  assign w_final_pop   = w_pop & r_win_last;
  // On the final pop the other bank may start immediately, leaving a single bubble.
  assign w_start_bank  = w_final_pop ? ~r_rd_bank : r_rd_bank;
  assign w_start       = (r_state[w_start_bank] == FULL) & (w_final_pop | ~r_out_valid);
  assign w_issue       = (r_state[r_rd_bank] == DRAINING) & (~r_out_valid | (w_pop & ~r_win_last));
  assign w_wr_bank_nxt = r_wr_bank ^ w_close;
  assign w_rd_bank_nxt = r_rd_bank ^ w_final_pop;

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) w_state_nxt[b] = r_state[b];
    w_in_ready_nxt = 1'b0;
    if (w_wr && r_state[r_wr_bank] == EMPTY) w_state_nxt[r_wr_bank] = FILLING;
    if (w_close)     w_state_nxt[r_wr_bank]    = FULL;
    if (w_final_pop) w_state_nxt[r_rd_bank]    = EMPTY;
    if (w_start)     w_state_nxt[w_start_bank] = DRAINING;
    w_in_ready_nxt = (w_state_nxt[w_wr_bank_nxt] == EMPTY) |
                     (w_state_nxt[w_wr_bank_nxt] == FILLING);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int b = 0; b < NUM_BANKS; b++) r_state[b] <= EMPTY;
      r_wr_bank    <= 1'b0;
      r_rd_bank    <= 1'b0;
      r_out_sel    <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_win_last   <= 1'b0;
      r_frame_last <= 1'b0;
      r_win_len    <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) r_state[b] <= w_state_nxt[b];
      r_wr_bank  <= w_wr_bank_nxt;
      r_rd_bank  <= w_rd_bank_nxt;
      r_in_ready <= w_in_ready_nxt;
      if (w_close)   r_wr_ptr <= '0;
      else if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_start) begin
        r_rd_ptr  <= AW'(w_len[w_start_bank] - (AW+1)'(1));
        r_win_len <= w_len[w_start_bank];
      end else if (w_issue && r_rd_ptr != '0) begin
        r_rd_ptr <= r_rd_ptr - AW'(1);
      end
      if (w_issue) begin
        r_out_valid  <= 1'b1;
        r_out_sel    <= r_rd_bank;
        r_win_last   <= (r_rd_ptr == '0);
        r_frame_last <= (r_rd_ptr == '0) & w_frame[r_rd_bank];
      end else if (w_pop) begin
        r_out_valid  <= 1'b0;
        r_win_last   <= 1'b0;
        r_frame_last <= 1'b0;
      end
    end
  end

`ifdef ALPHA_WINDOW_BUFFER_PARITY_EN
  logic r_parity_err;
  assign w_wr_data = {^i_alpha_in, i_alpha_in};

  // Stored bit makes the whole entry even; any odd entry popped latches the error.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_parity_err <= 1'b0;
    else if (w_pop && (^w_rd_data[r_out_sel])) r_parity_err <= 1'b1;
  end
  assign o_parity_err = r_parity_err;
`else
  assign w_wr_data = i_alpha_in;
`endif

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    alpha_buf_bank #(
      .DW (DW),
      .W  (W)
    ) u_bank (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_wr_en   (w_wr & (r_wr_bank == 1'(b))),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (w_wr_data),
      .i_close   (w_close & (r_wr_bank == 1'(b))),
      .i_len     (w_close_len),
      .i_frame   (i_in_frame_last),
      .i_rd_en   (w_issue & (r_rd_bank == 1'(b))),
      .i_rd_addr (r_rd_ptr),
      .o_rd_data (w_rd_data[b]),
      .o_len     (w_len[b]),
      .o_frame   (w_frame[b])
    );
  end

  assign o_in_ready       = r_in_ready;
  assign o_out_valid      = r_out_valid;
  assign o_alpha_out      = w_rd_data[r_out_sel][AB-1:0];
  assign o_out_win_last   = r_win_last;
  assign o_out_frame_last = r_frame_last;
  assign o_win_len        = r_win_len;

endmodule
